// File: rtl/spi_peripheral_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : spi_peripheral_regfile
//  Brief    : Mode-0 SPI responder. A command byte (bit7 = write, bits 6:0 =
//             address) is followed by an unlimited burst of data bytes that
//             write and/or read back a local register file with
//             auto-increment. Emits a one-clk write strobe per register
//             update and a one-clk frame error pulse on a mid-byte deselect.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_peripheral_regfile #(
  parameter int REG_WIDTH  = 8,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          spi_clk,
  input  logic                          spi_cs_n,
  input  logic                          serial_in,
  output logic                          serial_out,
  output logic [NUM_REGS*REG_WIDTH-1:0] reg_file_flat,
  output logic                          wr_strobe,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic                          frame_error
);

  localparam int                  C_CNT_W       = $clog2(REG_WIDTH);
  localparam logic [C_CNT_W-1:0]  C_LAST_BIT    = C_CNT_W'(REG_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] C_NUM_REGS_X  = (ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Synchronizers. spi_clk and spi_cs_n carry a third stage for edge
  // detection; serial_in carries a third stage too so that the sampled data
  // bit has exactly the same age as the spi_clk level that produced the edge.
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] cs_sync_q,   cs_sync_d;
  logic [2:0] mosi_sync_q, mosi_sync_d;

  // Registered edge pulses (one clk wide, three clk after the pin edge).
  logic sclk_rise_q, sclk_rise_d;
  logic sclk_fall_q, sclk_fall_d;
  logic cs_rise_q,   cs_rise_d;
  logic cs_fall_q,   cs_fall_d;

  // Protocol state.
  state_t                 state_q,    state_d;
  logic [C_CNT_W-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [REG_WIDTH-1:0]   rx_q,       rx_d;
  logic [REG_WIDTH-1:0]   tx_q,       tx_d;
  logic                   is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0]  addr_q,     addr_d;
  logic                   serial_out_q,  serial_out_d;
  logic                   wr_strobe_q,   wr_strobe_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q,     wr_addr_d;
  logic                   frame_error_q, frame_error_d;

  logic [REG_WIDTH-1:0] regs_q [NUM_REGS];
  logic [REG_WIDTH-1:0] regs_d [NUM_REGS];

  logic [REG_WIDTH-1:0] rx_next;
  logic [REG_WIDTH-1:0] rd_data;
  logic                 addr_in_range;

  // Synchronizer shifts and edge detection from the two oldest stages.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], spi_clk};
    cs_sync_d   = {cs_sync_q[1:0],   spi_cs_n};
    mosi_sync_d = {mosi_sync_q[1:0], serial_in};
    sclk_rise_d =  sclk_sync_q[1] & ~sclk_sync_q[2];
    sclk_fall_d = ~sclk_sync_q[1] &  sclk_sync_q[2];
    cs_rise_d   =  cs_sync_q[1]   & ~cs_sync_q[2];
    cs_fall_d   = ~cs_sync_q[1]   &  cs_sync_q[2];
  end

  // Read mux for the addressed register; out-of-range addresses read zero.
  always_comb begin
    addr_in_range = ({1'b0, addr_q} < C_NUM_REGS_X);
    rd_data       = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == ADDR_WIDTH'(i)) begin
        rd_data = regs_q[i];
      end
    end
    rx_next = {rx_q[REG_WIDTH-2:0], mosi_sync_q[2]};
  end

  // Next-state logic for the command/data protocol and the register file.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    is_write_d    = is_write_q;
    addr_d        = addr_q;
    serial_out_d  = serial_out_q;
    wr_strobe_d   = 1'b0;
    wr_addr_d     = wr_addr_q;
    frame_error_d = 1'b0;
    regs_d        = regs_q;

    unique case (state_q)
      ST_IDLE: begin
        bit_cnt_d    = '0;
        serial_out_d = 1'b0;
        if (cs_fall_q) begin
          state_d = ST_CMD;
          rx_d    = '0;
          tx_d    = '0;
        end
      end

      ST_CMD: begin
        if (sclk_rise_q) begin
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + C_CNT_W'(1);
          if (bit_cnt_q == C_LAST_BIT) begin
            is_write_d = rx_next[REG_WIDTH-1];
            addr_d     = rx_next[ADDR_WIDTH-1:0];
            state_d    = ST_DATA;
          end
        end
        // The TX register keeps moving in CMD but MISO is held low.
        if (sclk_fall_q) begin
          tx_d = (bit_cnt_q == '0) ? rd_data : (tx_q << 1);
        end
      end

      ST_DATA: begin
        if (sclk_rise_q) begin
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + C_CNT_W'(1);
          if (bit_cnt_q == C_LAST_BIT) begin
            if (is_write_q && addr_in_range) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_q == ADDR_WIDTH'(i)) begin
                  regs_d[i] = rx_next;
                end
              end
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
            end
            // Wrap inside the implemented range; beyond it, natural mod-128.
            addr_d = (addr_q == C_LAST_ADDR) ? '0 : (addr_q + ADDR_WIDTH'(1));
          end
        end
        // A byte boundary reloads from the (already advanced) address, so the
        // byte sent during a write is always the pre-write value.
        if (sclk_fall_q) begin
          tx_d         = (bit_cnt_q == '0) ? (addr_in_range ? rd_data : '0)
                                           : (tx_q << 1);
          serial_out_d = tx_d[REG_WIDTH-1];
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Deselect wins over everything, but only after a coincident 8th edge has
    // been accounted for, so a completed byte is never flagged as an error.
    if (cs_rise_q) begin
      frame_error_d = (state_q != ST_IDLE) && (bit_cnt_d != '0);
      state_d       = ST_IDLE;
      bit_cnt_d     = '0;
      serial_out_d  = 1'b0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_q   <= '0;
      cs_sync_q     <= '0;
      mosi_sync_q   <= '0;
      sclk_rise_q   <= 1'b0;
      sclk_fall_q   <= 1'b0;
      cs_rise_q     <= 1'b0;
      cs_fall_q     <= 1'b0;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      is_write_q    <= 1'b0;
      addr_q        <= '0;
      serial_out_q  <= 1'b0;
      wr_strobe_q   <= 1'b0;
      wr_addr_q     <= '0;
      frame_error_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_rise_q   <= sclk_rise_d;
      sclk_fall_q   <= sclk_fall_d;
      cs_rise_q     <= cs_rise_d;
      cs_fall_q     <= cs_fall_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      is_write_q    <= is_write_d;
      addr_q        <= addr_d;
      serial_out_q  <= serial_out_d;
      wr_strobe_q   <= wr_strobe_d;
      wr_addr_q     <= wr_addr_d;
      frame_error_q <= frame_error_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign reg_file_flat[g*REG_WIDTH +: REG_WIDTH] = regs_q[g];
    end
  endgenerate

  assign serial_out  = serial_out_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign frame_error = frame_error_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_peripheral_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_peripheral_regfile
//  Brief    : Directed bench for spi_peripheral_regfile. Drives mode-0 SPI
//             frames at 1/16 of the system clock and checks register file,
//             MISO data, write strobes and frame errors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_peripheral_regfile;

  logic         clk = 1'b0;
  logic         rstn;
  logic         spi_clk;
  logic         spi_cs_n;
  logic         serial_in;
  logic         serial_out;
  logic [127:0] reg_file_flat;
  logic         wr_strobe;
  logic [6:0]   wr_addr;
  logic         frame_error;

  spi_peripheral_regfile #(
    .REG_WIDTH  (8),
    .NUM_REGS   (16),
    .ADDR_WIDTH (7)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .spi_clk       (spi_clk),
    .spi_cs_n      (spi_cs_n),
    .serial_in     (serial_in),
    .serial_out    (serial_out),
    .reg_file_flat (reg_file_flat),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .frame_error   (frame_error)
  );

  always #5 clk = ~clk;

  int         n_asserts = 0;
  int         n_fails   = 0;
  int         strobe_cnt = 0;
  int         ferr_cnt   = 0;
  logic [6:0] strobe_log [$];
  logic [127:0] exp_flat;
  logic [7:0]   rx;

  // Count high cycles of the pulse outputs, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt++;
      strobe_log.push_back(wr_addr);
    end
    if (frame_error === 1'b1) ferr_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift n bits of d MSB first; MISO captured on each rising edge.
  task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      serial_in = d[i];
      #80 spi_clk = 1'b1;
      r[i] = serial_out;
      #80 spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #80 spi_cs_n = 1'b1;
    #160;
  endtask

  initial begin
    rstn      = 1'b0;
    spi_clk   = 1'b0;
    spi_cs_n  = 1'b1;
    serial_in = 1'b0;
    exp_flat  = '0;
    #40;
    // Reset state
    chk("reset_flat",   reg_file_flat, '0);
    chk("reset_miso",   serial_out,    '0);
    chk("reset_strobe", wr_strobe,     '0);
    chk("reset_waddr",  wr_addr,       '0);
    chk("reset_ferr",   frame_error,   '0);
    rstn = 1'b1;
    #100;

    // Single write reg3 <= A5; returned data is the old value 00
    cs_low();
    spi_bits(8'h83, 8, rx);
    spi_bits(8'hA5, 8, rx);
    cs_high();
    exp_flat[3*8 +: 8] = 8'hA5;
    chk("wr3_miso",   rx,            8'h00);
    chk("wr3_flat",   reg_file_flat, exp_flat);
    chk("wr3_nstb",   strobe_cnt,    1);
    chk("wr3_waddr",  wr_addr,       7'd3);

    // Read reg3
    cs_low();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h00, 8, rx);
    cs_high();
    chk("rd3_data", rx,         8'hA5);
    chk("rd3_nstb", strobe_cnt, 1);

    // Burst write from 14, wrapping to 0
    cs_low();
    spi_bits(8'h8E, 8, rx);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h22, 8, rx);
    spi_bits(8'h33, 8, rx);
    cs_high();
    exp_flat[14*8 +: 8] = 8'h11;
    exp_flat[15*8 +: 8] = 8'h22;
    exp_flat[0*8 +: 8]  = 8'h33;
    chk("burst_flat",  reg_file_flat, exp_flat);
    chk("burst_nstb",  strobe_cnt,    4);
    chk("burst_a0",    strobe_log[1], 7'd14);
    chk("burst_a1",    strobe_log[2], 7'd15);
    chk("burst_a2",    strobe_log[3], 7'd0);
    chk("burst_waddr", wr_addr,       7'd0);

    // Burst read across the wrap
    cs_low();
    spi_bits(8'h0E, 8, rx);
    spi_bits(8'h00, 8, rx);
    chk("brd_14", rx, 8'h11);
    spi_bits(8'h00, 8, rx);
    chk("brd_15", rx, 8'h22);
    spi_bits(8'h00, 8, rx);
    chk("brd_0",  rx, 8'h33);
    spi_bits(8'h00, 8, rx);
    chk("brd_1",  rx, 8'h00);
    cs_high();

    // Out-of-range write dropped, read returns zero
    cs_low();
    spi_bits(8'hA0, 8, rx);
    spi_bits(8'h5A, 8, rx);
    cs_high();
    chk("oor_flat", reg_file_flat, exp_flat);
    chk("oor_nstb", strobe_cnt,    4);
    cs_low();
    spi_bits(8'h20, 8, rx);
    spi_bits(8'hFF, 8, rx);
    cs_high();
    chk("oor_rd", rx, 8'h00);

    // Overwrite reg3: returned byte is the pre-write value
    cs_low();
    spi_bits(8'h83, 8, rx);
    spi_bits(8'h3C, 8, rx);
    cs_high();
    exp_flat[3*8 +: 8] = 8'h3C;
    chk("ovw_miso", rx,            8'hA5);
    chk("ovw_flat", reg_file_flat, exp_flat);
    chk("ovw_nstb", strobe_cnt,    5);
    chk("clean_ferr", ferr_cnt,    0);

    // Deselect after 4 data bits of a write to reg5
    cs_low();
    spi_bits(8'h85, 8, rx);
    spi_bits(8'hC3, 4, rx);
    cs_high();
    chk("ferr_cnt",  ferr_cnt,      1);
    chk("ferr_flat", reg_file_flat, exp_flat);
    chk("ferr_nstb", strobe_cnt,    5);
    cs_low();
    spi_bits(8'h85, 8, rx);
    spi_bits(8'h6B, 8, rx);
    cs_high();
    exp_flat[5*8 +: 8] = 8'h6B;
    chk("after_ferr_flat", reg_file_flat, exp_flat);
    chk("after_ferr_nstb", strobe_cnt,    6);

    // Reset in the middle of a write to reg2
    cs_low();
    spi_bits(8'h82, 8, rx);
    spi_bits(8'h77, 8, rx);
    cs_high();
    exp_flat[2*8 +: 8] = 8'h77;
    chk("pre_rst_flat", reg_file_flat, exp_flat);
    cs_low();
    spi_bits(8'h82, 8, rx);
    spi_bits(8'hFF, 6, rx);
    #20 rstn = 1'b0;
    #1;
    chk("rst_flat",   reg_file_flat, '0);
    chk("rst_miso",   serial_out,    '0);
    chk("rst_strobe", wr_strobe,     '0);
    chk("rst_waddr",  wr_addr,       '0);
    chk("rst_ferr",   frame_error,   '0);
    #19 rstn = 1'b1;
    #40;
    // Frame still selected after reset: must be ignored
    spi_bits(8'hFF, 2, rx);
    spi_bits(8'h82, 8, rx);
    spi_bits(8'h99, 8, rx);
    cs_high();
    chk("ign_flat", reg_file_flat, '0);
    chk("ign_nstb", strobe_cnt,    7);
    chk("ign_ferr", ferr_cnt,      1);
    cs_low();
    spi_bits(8'h82, 8, rx);
    spi_bits(8'h44, 8, rx);
    cs_high();
    exp_flat = '0;
    exp_flat[2*8 +: 8] = 8'h44;
    chk("post_rst_flat",  reg_file_flat, exp_flat);
    chk("post_rst_nstb",  strobe_cnt,    8);
    chk("post_rst_waddr", wr_addr,       7'd2);
    chk("post_rst_miso",  rx,            8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #2000000;
    n_fails++;
    $display("FAIL timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
